// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single write port of one Fifo (write clock domain) among
//   REQUESTERS producers. Arbitration is round-robin, and each grant can
//   accept at most BURST words before the grant is forced to rotate.
//
// Optional feature:
//   FIFO_WR_ARBITER_STATS_EN  When defined, `stalls` is a saturating count
//                             of full-blocked cycles. When not defined,
//                             `stalls` is tied to zero.
//
// Ports
//   clk     in   1                 single clock (= Fifo wrclk)
//   rst     in   1                 synchronous, active-high reset
//   req     in   REQUESTERS        req[i]: producer i presents a valid word
//   data    in   REQUESTERS*WIDTH  word of producer i at data[i*WIDTH +: WIDTH]
//   ack     out  REQUESTERS        one-hot; word of producer i consumed this cycle
//   grant   out  REQUESTERS        one-hot current owner, zero when idle
//   full    in   1                 Fifo full flag
//   wrena   out  1                 Fifo write enable
//   wrdata  out  WIDTH             Fifo write data
//   stalls  out  16                full-blocked cycle count (stats build only)
module fifo_wr_arbiter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned BURST      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REQUESTERS-1:0]       req,
  input  logic [REQUESTERS*WIDTH-1:0] data,
  output logic [REQUESTERS-1:0]       ack,
  output logic [REQUESTERS-1:0]       grant,
  input  logic                        full,
  output logic                        wrena,
  output logic [WIDTH-1:0]            wrdata,
  output logic [15:0]                 stalls
);

  localparam int unsigned IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int unsigned BW = $clog2(BURST + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_e;

  state_e                state_q;
  logic [IW-1:0]         g_q;
  logic [IW-1:0]         ptr_q;
  logic [BW-1:0]         burst_q;
  logic [REQUESTERS-1:0] grant_q;

  logic [IW-1:0]         scan_start;
  logic [IW-1:0]         pick_d;
  logic                  pick_vld_d;
  logic [IW-1:0]         ptr_d;
  logic [REQUESTERS-1:0] pick_oh_d;
  logic                  own;
  logic                  burst_last;

  assign own        = (state_q == S_OWN);
  assign burst_last = (burst_q == BW'(BURST - 1));

  // The write path is combinational from the registered grant, so there is
  // no latency: a word is written in exactly the cycle its ack is high.
  assign wrena  = ~rst & own & req[g_q] & ~full;
  assign wrdata = data[32'(g_q)*WIDTH +: WIDTH];
  assign ack    = wrena ? grant_q : '0;
  assign grant  = grant_q;

  // Round-robin scan. From IDLE the scan starts at the pointer. While a
  // grant is held, it starts at g+1, so the current owner is checked last.
  always_comb begin
    scan_start = own ? IW'((32'(g_q) + 1) % REQUESTERS) : ptr_q;
    pick_d     = '0;
    pick_vld_d = 1'b0;
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      if (!pick_vld_d && req[(32'(scan_start) + k) % REQUESTERS]) begin
        pick_d     = IW'((32'(scan_start) + k) % REQUESTERS);
        pick_vld_d = 1'b1;
      end
    end
    ptr_d     = IW'((32'(pick_d) + 1) % REQUESTERS);
    pick_oh_d = REQUESTERS'(1) << pick_d;
  end

  // Arbitration FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            state_q <= S_OWN;
            g_q     <= pick_d;
            ptr_q   <= ptr_d;
            burst_q <= '0;
            grant_q <= pick_oh_d;
          end
        end
        S_OWN: begin
          if (!req[g_q]) begin
            // The owner withdrew its request. This costs one bubble cycle
            // before the next owner is selected.
            burst_q <= '0;
            if (pick_vld_d) begin
              g_q     <= pick_d;
              ptr_q   <= ptr_d;
              grant_q <= pick_oh_d;
            end else begin
              state_q <= S_IDLE;
              grant_q <= '0;
            end
          end else if (wrena) begin
            if (burst_last) begin
              // req[g] is set here, so the pick is always valid. A sole
              // requester gets re-granted to itself with no bubble.
              g_q     <= pick_d;
              ptr_q   <= ptr_d;
              burst_q <= '0;
              grant_q <= pick_oh_d;
            end else begin
              burst_q <= burst_q + BW'(1);
            end
          end
          // When blocked by full, hold the owner and burst count so that
          // no word is dropped.
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0] stalls_q;

  // Saturating count of cycles where a request is blocked by full.
  always_ff @(posedge clk) begin
    if (rst) begin
      stalls_q <= '0;
    end else if ((|req) && full && (stalls_q != 16'hFFFF)) begin
      stalls_q <= stalls_q + 16'd1;
    end
  end

  assign stalls = stalls_q;
`else
  assign stalls = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed arbitration scenarios with a
// write-order scoreboard, then a long run against a slow Fifo reader.
module tb_fifo_wr_arbiter;

  localparam int unsigned W = 8;
  localparam int unsigned R = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [R-1:0]   req;
  logic [R*W-1:0] data;
  logic [R-1:0]   ack;
  logic [R-1:0]   grant;
  logic           full;
  logic           wrena;
  logic [W-1:0]   wrdata;
  logic [15:0]    stalls;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.WIDTH(W), .REQUESTERS(R), .BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack), .grant(grant),
    .full(full), .wrena(wrena), .wrdata(wrdata), .stalls(stalls)
  );

  typedef struct {
    int         p;
    logic [W-1:0] w;
  } exp_t;

  exp_t     sb[$];
  int       checks = 0;
  int       failures = 0;
  int       cnt[R];
  int       rem[R];
  int       exp_cnt[R];
  int       writes = 0;
  int       cyc = 0;
  int       first_wr = -1;
  int       last_wr = -1;
  bit       random_mode = 1'b0;
  logic [R-1:0] ack_s;
  int       w0;
  int       occ;
  int       guard;

  function automatic logic [W-1:0] word(int p, int c);
    return W'(p * 64 + c);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(int p, int n);
    repeat (n) begin
      sb.push_back('{p, word(p, exp_cnt[p])});
      exp_cnt[p]++;
    end
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < int'(R); p++) begin
      req[p]         = (rem[p] > 0);
      data[p*W +: W] = word(p, cnt[p]);
    end
  endtask

  // One clock cycle: inputs are driven, outputs are sampled at the negedge,
  // and producers advance after the posedge on the acks they received.
  task automatic cycle(input bit chk_g = 1'b0, input logic [R-1:0] eg = '0);
    int   p;
    exp_t e;
    drive_inputs();
    @(negedge clk);
    if (chk_g) chk("grant", 32'(grant), 32'(eg));
    if (rst) chk("rst_wrena", 32'(wrena), 32'd0);
    if (full) chk("no_write_when_full", 32'(wrena), 32'd0);
    if (wrena) begin
      writes++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (random_mode) begin
        chk("ack_onehot", 32'($onehot(ack)), 32'd1);
        p = 0;
        for (int i = 0; i < int'(R); i++) if (ack[i]) p = i;
        chk("order_wrdata", 32'(wrdata), 32'(word(p, exp_cnt[p])));
        exp_cnt[p]++;
      end else if (sb.size() == 0) begin
        chk("unexpected_write", 32'(wrena), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack", 32'(ack), 32'd1 << e.p);
        chk("wrdata", 32'(wrdata), 32'(e.w));
      end
    end else begin
      chk("ack_idle", 32'(ack), 32'd0);
    end
    ack_s = ack;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < int'(R); i++) begin
      if (ack_s[i]) begin
        cnt[i]++;
        rem[i]--;
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    full = 1'b0;
    for (int i = 0; i < int'(R); i++) begin
      cnt[i] = 0; rem[i] = 0; exp_cnt[i] = 0;
    end
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with all requests asserted.
    for (int i = 0; i < int'(R); i++) rem[i] = 4;
    cycle(1'b1, 4'b0000);
    chk("rst_stalls", 32'(stalls), 32'd0);

    // All four requesters: one IDLE cycle, then bursts of 4 for 0, 1, 2, 3.
    push(0, 4); push(1, 4); push(2, 4); push(3, 4);
    rst = 1'b0;
    w0 = writes;
    cycle(1'b1, 4'b0000);
    for (int k = 0; k < 16; k++) cycle(1'b1, 4'(1 << (k / 4)));
    chk("t1_writes", 32'(writes - w0), 32'd16);
    repeat (2) cycle();
    cycle(1'b1, 4'b0000);

    // A sole requester takes 10 words with no gap at burst boundaries.
    rem[2] = 10; push(2, 10);
    w0 = writes; first_wr = -1;
    cycle(1'b1, 4'b0000);
    repeat (10) cycle(1'b1, 4'b0100);
    chk("t2_writes", 32'(writes - w0), 32'd10);
    chk("t2_contiguous", 32'(last_wr - first_wr + 1), 32'd10);
    repeat (2) cycle();
    cycle(1'b1, 4'b0000);

    // Owner 1 drops after 2 words while 3 waits: one bubble, then grant 3.
    rem[1] = 2; push(1, 2); push(3, 2);
    cycle(1'b1, 4'b0000);
    rem[3] = 2;
    cycle(1'b1, 4'b0010);
    cycle(1'b1, 4'b0010);
    cycle(1'b1, 4'b0010);
    cycle(1'b1, 4'b1000);
    cycle(1'b1, 4'b1000);
    cycle();
    cycle(1'b1, 4'b0000);
    // The pointer now points at 0, so 0 wins over 1 and 2.
    rem[0] = 1; rem[1] = 1; rem[2] = 1;
    push(0, 1); push(1, 1); push(2, 1);
    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0001);
    cycle(1'b1, 4'b0001);
    cycle(1'b1, 4'b0010);
    cycle(1'b1, 4'b0010);
    cycle(1'b1, 4'b0100);
    cycle(1'b1, 4'b0100);
    cycle(1'b1, 4'b0000);

    // full held for 5 cycles at burst_cnt 2 of requester 0.
    rem[0] = 4; rem[1] = 4; push(0, 4); push(1, 4);
    cycle(1'b1, 4'b0000);
    repeat (2) cycle(1'b1, 4'b0001);
    full = 1'b1;
    repeat (5) cycle(1'b1, 4'b0001);
    full = 1'b0;
    repeat (2) cycle(1'b1, 4'b0001);
    repeat (4) cycle(1'b1, 4'b0010);
    cycle();
    cycle(1'b1, 4'b0000);
`ifdef FIFO_WR_ARBITER_STATS_EN
    chk("stalls", 32'(stalls), 32'd5);
`else
    chk("stalls", 32'(stalls), 32'd0);
`endif

    // Reset mid-burst: no write that cycle, IDLE next, restart from 0.
    rem[3] = 8; rem[0] = 8; push(3, 2);
    cycle(1'b1, 4'b0000);
    repeat (2) cycle(1'b1, 4'b1000);
    rst = 1'b1;
    cycle(1'b1, 4'b1000);
    rst = 1'b0;
    cycle(1'b1, 4'b0000);
    chk("post_rst_stalls", 32'(stalls), 32'd0);
    push(0, 4); push(3, 4); push(0, 4); push(3, 2);
    repeat (4) cycle(1'b1, 4'b0001);
    repeat (4) cycle(1'b1, 4'b1000);
    repeat (4) cycle(1'b1, 4'b0001);
    repeat (2) cycle(1'b1, 4'b1000);
    cycle();
    cycle(1'b1, 4'b0000);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // 4 x 250 words into a 99-deep Fifo drained by a slow random reader.
    random_mode = 1'b1;
    for (int i = 0; i < int'(R); i++) begin
      cnt[i] = 0; exp_cnt[i] = 0; rem[i] = 250;
    end
    w0 = writes; occ = 0; guard = 0;
    while ((writes - w0) < 1000 && guard < 20000) begin
      full = (occ >= 99);
      cycle();
      if (|ack_s) occ++;
      if (occ > 0 && $urandom_range(0, 9) < 4) occ--;
      guard++;
    end
    full = 1'b0;
    chk("e2e_total", 32'(writes - w0), 32'd1000);
    for (int i = 0; i < int'(R); i++) chk("e2e_per_producer", 32'(exp_cnt[i]), 32'd250);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
